// File: rtl/washing_machine.sv
// Washing-machine cycle controller: a timed phase sequencer with abort-to-drain,
// hold-in-DONE until start drops, and outputs decoded directly from the state register.
module washing_machine #(
  parameter int FILL_CYC  = 4,
  parameter int WASH_CYC  = 8,
  parameter int RINSE_CYC = 4,
  parameter int DRAIN_CYC = 3,
  parameter int SPIN_CYC  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       water_in,
  output logic       drain,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_WASH   = 4'd2,
    S_DRAIN1 = 4'd3,
    S_RFILL  = 4'd4,
    S_RINSE  = 4'd5,
    S_DRAIN2 = 4'd6,
    S_SPIN   = 4'd7,
    S_DONE   = 4'd8,
    S_ABORT  = 4'd9
  } state_t;

  // Counter preload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [7:0] FILL_LD  = 8'(FILL_CYC - 1);
  localparam logic [7:0] WASH_LD  = 8'(WASH_CYC - 1);
  localparam logic [7:0] RINSE_LD = 8'(RINSE_CYC - 1);
  localparam logic [7:0] DRAIN_LD = 8'(DRAIN_CYC - 1);
  localparam logic [7:0] SPIN_LD  = 8'(SPIN_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       expired;

  assign expired = (cnt_q == 8'd0);

  function automatic state_t next_phase(input state_t s);
    case (s)
      S_FILL:   next_phase = S_WASH;
      S_WASH:   next_phase = S_DRAIN1;
      S_DRAIN1: next_phase = S_RFILL;
      S_RFILL:  next_phase = S_RINSE;
      S_RINSE:  next_phase = S_DRAIN2;
      S_DRAIN2: next_phase = S_SPIN;
      S_SPIN:   next_phase = S_DONE;
      default:  next_phase = S_IDLE;
    endcase
  endfunction

  function automatic logic [7:0] load_for(input state_t s);
    case (s)
      S_FILL, S_RFILL:             load_for = FILL_LD;
      S_WASH:                      load_for = WASH_LD;
      S_RINSE:                     load_for = RINSE_LD;
      S_DRAIN1, S_DRAIN2, S_ABORT: load_for = DRAIN_LD;
      S_SPIN:                      load_for = SPIN_LD;
      default:                     load_for = 8'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
          cnt_d   = FILL_LD;
        end
      end
      S_FILL, S_WASH, S_DRAIN1, S_RFILL, S_RINSE, S_DRAIN2, S_SPIN: begin
        // Dropping start wins over a phase expiring on the same edge.
        if (!start) begin
          state_d = S_ABORT;
          cnt_d   = DRAIN_LD;
        end else if (expired) begin
          state_d = next_phase(state_q);
          cnt_d   = load_for(next_phase(state_q));
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      end
      S_ABORT: begin
        if (expired) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    water_in   = 1'b0;
    drain      = 1'b0;
    motor_on   = 1'b0;
    motor_fast = 1'b0;
    door_lock  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_FILL, S_RFILL: begin
        water_in  = 1'b1;
        door_lock = 1'b1;
        busy      = 1'b1;
      end
      S_WASH, S_RINSE: begin
        motor_on  = 1'b1;
        door_lock = 1'b1;
        busy      = 1'b1;
      end
      S_DRAIN1, S_DRAIN2, S_ABORT: begin
        drain     = 1'b1;
        door_lock = 1'b1;
        busy      = 1'b1;
      end
      S_SPIN: begin
        motor_on   = 1'b1;
        motor_fast = 1'b1;
        drain      = 1'b1;
        door_lock  = 1'b1;
        busy       = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_washing_machine.sv
// Directed bench for washing_machine: reset, full run, aborts, abort priority,
// asynchronous mid-cycle reset and DONE handshake, all with hand-derived expectations.
module tb_washing_machine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       water_in, drain, motor_on, motor_fast, door_lock, busy, done;
  logic [3:0] state;
  logic [6:0] obs;

  int checks   = 0;
  int failures = 0;

  washing_machine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .water_in  (water_in),
    .drain     (drain),
    .motor_on  (motor_on),
    .motor_fast(motor_fast),
    .door_lock (door_lock),
    .busy      (busy),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  // {water_in, drain, motor_on, motor_fast, door_lock, busy, done}
  assign obs = {water_in, drain, motor_on, motor_fast, door_lock, busy, done};

  function automatic logic [6:0] exp_outs(input logic [3:0] st);
    case (st)
      4'd1, 4'd4:       exp_outs = 7'b1000110;
      4'd2, 4'd5:       exp_outs = 7'b0010110;
      4'd3, 4'd6, 4'd9: exp_outs = 7'b0100110;
      4'd7:             exp_outs = 7'b0111110;
      4'd8:             exp_outs = 7'b0000001;
      default:          exp_outs = 7'b0000000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    #12;
    checks++;
    if ({state, obs} !== 11'd0) begin
      failures++;
      $display("FAIL reset_hold state=%0d outs=%b expected state=0 outs=0000000", state, obs);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({state, obs} !== 11'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d state=%0d outs=%b expected state=0 outs=0000000", i, state, obs);
      end
    end
    $display("tb: test_reset done");
  endtask

  task automatic test_normal_run();
    logic [3:0] codes [7];
    int         durs  [7];
    codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    durs  = '{4, 8, 3, 4, 4, 3, 6};
    start = 1'b1;
    for (int p = 0; p < 7; p++) begin
      for (int k = 0; k < durs[p]; k++) begin
        tick();
        checks++;
        if ({state, obs} !== {codes[p], exp_outs(codes[p])}) begin
          failures++;
          $display("FAIL run_seq phase=%0d cyc=%0d state=%0d outs=%b expected state=%0d outs=%b",
                   p, k, state, obs, codes[p], exp_outs(codes[p]));
        end
      end
    end
    // Holding start through DONE must not restart.
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({state, obs} !== {4'd8, 7'b0000001}) begin
        failures++;
        $display("FAIL done_hold cyc=%0d state=%0d outs=%b expected state=8 outs=0000001", i, state, obs);
      end
    end
    start = 1'b0;
    tick();
    checks++;
    if ({state, obs} !== 11'd0) begin
      failures++;
      $display("FAIL done_to_idle state=%0d outs=%b expected state=0 outs=0000000", state, obs);
    end
    start = 1'b1;
    tick();
    checks++;
    if ({state, obs} !== {4'd1, 7'b1000110}) begin
      failures++;
      $display("FAIL idle_restart state=%0d outs=%b expected state=1 outs=1000110", state, obs);
    end
    start = 1'b0;
    tick();
    checks++;
    if (state !== 4'd9) begin
      failures++;
      $display("FAIL restart_abort state=%0d expected 9", state);
    end
    repeat (3) tick();
    checks++;
    if ({state, obs} !== 11'd0) begin
      failures++;
      $display("FAIL restart_abort_idle state=%0d outs=%b expected state=0 outs=0000000", state, obs);
    end
    $display("tb: test_normal_run done");
  endtask

  task automatic test_abort();
    start = 1'b1;
    repeat (20) tick();
    checks++;
    if (state !== 4'd5) begin
      failures++;
      $display("FAIL abort_pre state=%0d expected 5", state);
    end
    start = 1'b0;
    tick();
    checks++;
    if ({state, obs} !== {4'd9, 7'b0100110}) begin
      failures++;
      $display("FAIL abort_entry state=%0d outs=%b expected state=9 outs=0100110", state, obs);
    end
    // start is ignored while draining after an abort.
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({state, obs} !== {4'd9, 7'b0100110}) begin
        failures++;
        $display("FAIL abort_drain cyc=%0d state=%0d outs=%b expected state=9 outs=0100110", i, state, obs);
      end
    end
    tick();
    checks++;
    if ({state, obs} !== 11'd0) begin
      failures++;
      $display("FAIL abort_exit state=%0d outs=%b expected state=0 outs=0000000", state, obs);
    end
    start = 1'b0;
    tick();
    checks++;
    if ({state, obs} !== 11'd0) begin
      failures++;
      $display("FAIL abort_idle state=%0d outs=%b expected state=0 outs=0000000", state, obs);
    end
    $display("tb: test_abort done");
  endtask

  task automatic test_abort_priority();
    start = 1'b1;
    repeat (12) tick();
    checks++;
    if (state !== 4'd2) begin
      failures++;
      $display("FAIL prio_last_wash state=%0d expected 2", state);
    end
    start = 1'b0;
    tick();
    checks++;
    if (state !== 4'd9) begin
      failures++;
      $display("FAIL prio_abort state=%0d expected 9", state);
    end
    repeat (2) tick();
    checks++;
    if (state !== 4'd9) begin
      failures++;
      $display("FAIL prio_abort_len state=%0d expected 9", state);
    end
    tick();
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL prio_idle state=%0d expected 0", state);
    end
    $display("tb: test_abort_priority done");
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    repeat (28) tick();
    checks++;
    if ({state, obs} !== {4'd7, 7'b0111110}) begin
      failures++;
      $display("FAIL spin_reach state=%0d outs=%b expected state=7 outs=0111110", state, obs);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({state, obs} !== 11'd0) begin
      failures++;
      $display("FAIL async_reset state=%0d outs=%b expected state=0 outs=0000000", state, obs);
    end
    #2;
    start = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({state, obs} !== 11'd0) begin
        failures++;
        $display("FAIL post_reset_idle cyc=%0d state=%0d outs=%b expected state=0", i, state, obs);
      end
    end
    start = 1'b1;
    tick();
    checks++;
    if (state !== 4'd1) begin
      failures++;
      $display("FAIL post_reset_start state=%0d expected 1", state);
    end
    start = 1'b0;
    tick();
    repeat (3) tick();
    checks++;
    if (state !== 4'd0) begin
      failures++;
      $display("FAIL post_reset_cleanup state=%0d expected 0", state);
    end
    $display("tb: test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_abort();
    test_abort_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/washing_machine.md
WASHING_MACHINE -- requirements
Module: washing_machine

Interface
REQ-001 Parameter FILL_CYC, default 4, cycles spent in each fill phase (FILL, RFILL); legal 1..255.
REQ-002 Parameter WASH_CYC, default 8, cycles spent in WASH; legal 1..255.
REQ-003 Parameter RINSE_CYC, default 4, cycles spent in RINSE; legal 1..255.
REQ-004 Parameter DRAIN_CYC, default 3, cycles spent in each drain phase (DRAIN1, DRAIN2, ABORT); legal 1..255.
REQ-005 Parameter SPIN_CYC, default 6, cycles spent in SPIN; legal 1..255.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  level-sensitive run request; high = run or keep running, low = stop.
REQ-009 water_in  output  1  fill valve open.
REQ-010 drain  output  1  drain pump on.
REQ-011 motor_on  output  1  drum motor running.
REQ-012 motor_fast  output  1  motor at spin speed; only ever high together with motor_on.
REQ-013 door_lock  output  1  door locked.
REQ-014 busy  output  1  a cycle is in progress, i.e. any state other than IDLE and DONE.
REQ-015 done  output  1  cycle completed normally.
REQ-016 state  output  4  current state code.

Function
REQ-017 The block SHALL implement these states and codes: IDLE=0, FILL=1, WASH=2, DRAIN1=3, RFILL=4, RINSE=5, DRAIN2=6, SPIN=7, DONE=8, ABORT=9.
REQ-018 All outputs SHALL be combinational decodes of the registered state: no glitches beyond the state register, and a zero-cycle lag from state to outputs.
REQ-019 Output decode SHALL be:
- FILL, RFILL: water_in=1.
- WASH, RINSE: motor_on=1.
- DRAIN1, DRAIN2, ABORT: drain=1.
- SPIN: motor_on=1, motor_fast=1, drain=1.
- DONE: done=1.
- door_lock=1 in every state except IDLE and DONE.
- All other outputs 0.
REQ-020 In IDLE, start=1 sampled on a clock edge SHALL move the block to FILL on that edge; start=0 keeps it in IDLE.
REQ-021 The normal sequence SHALL be FILL, WASH, DRAIN1, RFILL, RINSE, DRAIN2, SPIN, DONE.
REQ-022 Each timed state SHALL last exactly its parameter count of cycles, measured from entry, and then advance.
REQ-023 An internal 8-bit down-counter SHALL be loaded with the duration minus 1 on every state entry; the state advances when the counter reads 0.
REQ-024 Abort: start=0 sampled in any of FILL through SPIN SHALL send the block to ABORT on that edge.
REQ-025 Abort SHALL take priority over a timer expiry on the same edge.
REQ-026 ABORT SHALL last DRAIN_CYC cycles and then go to IDLE; start SHALL be ignored while in ABORT.
REQ-027 The block SHALL stay in DONE while start=1 and SHALL go to IDLE on the first edge with start=0, so there is no automatic restart.
REQ-028 From IDLE, a new cycle SHALL need start=1 sampled in IDLE; holding start high through DONE SHALL NOT restart the cycle.
REQ-029 A complete normal run with default parameters SHALL take 32 cycles from FILL entry to DONE entry.

Reset
REQ-030 Asserting reset SHALL immediately force state to IDLE, clear the counter, and drive every output to 0, regardless of clock or current state, including mid-cycle.
REQ-031 After reset deasserts, the block SHALL remain in IDLE until start=1 is sampled.

Verification
REQ-032 Reset, then start=0 for 5 cycles -> state=0; all outputs 0.
REQ-033 Hold start=1 with default parameters -> state sequence 1x4, 2x8, 3x3, 4x4, 5x4, 6x3, 7x6, then 8 held; done=1 and busy=0 from DONE entry.
REQ-034 Start=1 for 20 cycles, then 0 -> state=9 on the next edge; drain=1 and door_lock=1 for 3 cycles; then IDLE with all outputs 0.
REQ-035 Drop start on the same edge that WASH expires -> state goes to ABORT, not DRAIN1.
REQ-036 Assert reset asynchronously mid-SPIN, between clock edges -> all outputs 0 before the next clock edge; state=0.
REQ-037 In DONE, drop start -> IDLE on the next edge; reassert start -> FILL on the following sampled edge.
